// File: rtl/nes_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nes_mem_pkg
// Description : Shared types and constants for the NES memory arbiter.
//               Owner codes, arbiter state encoding and the address width.
// Revision    : 1.0 - initial release
// ============================================================================
package nes_mem_pkg;

  localparam int ADDR_W = 22;

  // Owner of the memory controller port; the numeric values are visible
  // on the owner output, so they are fixed explicitly.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PPU  = 2'd2,
    OWN_LDR  = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational requester selector. The loader always wins;
//               CPU and PPU alternate on a tie using the round-robin bit.
// Ports       : ldr_req, cpu_req, ppu_req - request levels
//               rr_cpu_last                - 1 when the CPU was served last
//               pick                       - selected owner code
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import nes_mem_pkg::*;
(
  input  logic   ldr_req,
  input  logic   cpu_req,
  input  logic   ppu_req,
  input  logic   rr_cpu_last,
  output owner_t pick
);

  always_comb begin
    pick = OWN_NONE;
    if (ldr_req) begin
      pick = OWN_LDR;
    end else if (cpu_req && ppu_req) begin
      pick = rr_cpu_last ? OWN_PPU : OWN_CPU;
    end else if (cpu_req) begin
      pick = OWN_CPU;
    end else if (ppu_req) begin
      pick = OWN_PPU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single MemoryController port between the cart
//               loader (writes), the CPU (reads/writes) and the PPU (reads).
//               One controller transaction at a time: strobe, wait for busy
//               to clear (or time out), then ack the winner with read data.
// Ports       : clk, reset_n (async, active-low)
//               ldr_req/addr/din/ack          - loader write channel
//               cpu_req/we/addr/din/ack/dout  - CPU channel (reads on a)
//               ppu_req/addr/ack/dout         - PPU read channel (reads on b)
//               mc_read_a/b, mc_write, mc_addr, mc_din,
//               mc_dout_a/b, mc_busy          - controller side
//               owner, timeout_err            - status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_din,
  output logic              ldr_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_ack,
  output logic [7:0]        ppu_dout,
  output logic              mc_read_a,
  output logic              mc_read_b,
  output logic              mc_write,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [7:0]        mc_din,
  input  logic [7:0]        mc_dout_a,
  input  logic [7:0]        mc_dout_b,
  input  logic              mc_busy,
  output logic [1:0]        owner,
  output logic              timeout_err
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_next;
  owner_t            r_owner;
  owner_t            w_pick;
  logic              r_rr_cpu_last;
  logic              r_we;
  logic [7:0]        r_wait_cnt;
  logic [7:0]        w_cnt_inc;
  logic              w_grant;
  logic              w_finish;
  logic              w_forced;

  logic              r_ldr_ack;
  logic              r_cpu_ack;
  logic              r_ppu_ack;
  logic [7:0]        r_cpu_dout;
  logic [7:0]        r_ppu_dout;
  logic              r_mc_read_a;
  logic              r_mc_read_b;
  logic              r_mc_write;
  logic [ADDR_W-1:0] r_mc_addr;
  logic [7:0]        r_mc_din;
  logic              r_timeout_err;

  mem_arb_pick u_pick (
    .ldr_req     (ldr_req),
    .cpu_req     (cpu_req),
    .ppu_req     (ppu_req),
    .rr_cpu_last (r_rr_cpu_last),
    .pick        (w_pick)
  );

  // Saturating increment; the value compared against the timeout is the
  // count of WAIT cycles including the current one.
  assign w_cnt_inc = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and transition decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_finish     = 1'b0;
    w_forced     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Never issue while the controller is still busy, e.g. with a
        // transaction left in flight across a reset.
        if ((w_pick != OWN_NONE) && !mc_busy) begin
          w_grant      = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mc_busy) begin
          w_finish     = 1'b1;
          w_state_next = ST_DONE;
        end else if (w_cnt_inc == c_timeout) begin
          w_finish     = 1'b1;
          w_forced     = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered datapath and outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner       <= OWN_NONE;
      r_rr_cpu_last <= 1'b0;
      r_we          <= 1'b0;
      r_wait_cnt    <= 8'h00;
      r_ldr_ack     <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_ppu_ack     <= 1'b0;
      r_cpu_dout    <= 8'h00;
      r_ppu_dout    <= 8'h00;
      r_mc_read_a   <= 1'b0;
      r_mc_read_b   <= 1'b0;
      r_mc_write    <= 1'b0;
      r_mc_addr     <= '0;
      r_mc_din      <= 8'h00;
      r_timeout_err <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses.
      r_mc_read_a <= 1'b0;
      r_mc_read_b <= 1'b0;
      r_mc_write  <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_ppu_ack   <= 1'b0;

      if (w_grant) begin
        r_owner <= w_pick;
        case (w_pick)
          OWN_LDR: begin
            r_we       <= 1'b1;
            r_mc_write <= 1'b1;
            r_mc_addr  <= ldr_addr;
            r_mc_din   <= ldr_din;
          end
          OWN_CPU: begin
            r_rr_cpu_last <= 1'b1;
            r_we          <= cpu_we;
            r_mc_write    <= cpu_we;
            r_mc_read_a   <= ~cpu_we;
            r_mc_addr     <= cpu_addr;
            r_mc_din      <= cpu_din;
          end
          OWN_PPU: begin
            r_rr_cpu_last <= 1'b0;
            r_we          <= 1'b0;
            r_mc_read_b   <= 1'b1;
            r_mc_addr     <= ppu_addr;
            r_mc_din      <= 8'h00;
          end
          default: begin
            r_we <= 1'b0;
          end
        endcase
      end

      if (r_state == ST_ISSUE) begin
        r_wait_cnt <= 8'h00;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= w_cnt_inc;
      end

      if (w_finish) begin
        r_ldr_ack <= (r_owner == OWN_LDR);
        r_cpu_ack <= (r_owner == OWN_CPU);
        r_ppu_ack <= (r_owner == OWN_PPU);
        // Read data is only written on reads; a forced completion
        // returns all-ones.
        if ((r_owner == OWN_CPU) && !r_we) begin
          r_cpu_dout <= w_forced ? 8'hFF : mc_dout_a;
        end
        if (r_owner == OWN_PPU) begin
          r_ppu_dout <= w_forced ? 8'hFF : mc_dout_b;
        end
        if (w_forced) begin
          r_timeout_err <= 1'b1;
        end
      end

      if (r_state == ST_DONE) begin
        r_owner <= OWN_NONE;
      end
    end
  end

  assign ldr_ack     = r_ldr_ack;
  assign cpu_ack     = r_cpu_ack;
  assign ppu_ack     = r_ppu_ack;
  assign cpu_dout    = r_cpu_dout;
  assign ppu_dout    = r_ppu_dout;
  assign mc_read_a   = r_mc_read_a;
  assign mc_read_b   = r_mc_read_b;
  assign mc_write    = r_mc_write;
  assign mc_addr     = r_mc_addr;
  assign mc_din      = r_mc_din;
  assign owner       = r_owner;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
